irq_ctrl: RTL

- Interrupt aggregation stage directly upstream of the CP0 block; drives CP0's 6-bit `interrupt` input.
- Synchronizes five asynchronous external IRQ lines and latches edge-mode events into a pending register.
- Includes a count/compare interval timer that sources interrupt line 5.
- Software reaches a small register file through a word-addressed CPU bus port.

---
 rtl/irq_ctrl.sv | 125 ++++++++++++
 1 files changed

// File: rtl/irq_ctrl.sv
// Interrupt aggregator feeding CP0: synchronized external lines with per-line
// edge/level capture, a count/compare interval timer on line 5, and a small register file.
module irq_ctrl #(
    parameter int SYNC_STAGES = 2,
    parameter int TIMER_W     = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  irq_in,
    input  logic [1:0]  addr,
    input  logic        we,
    input  logic [31:0] wd,
    output logic [31:0] rd,
    output logic [5:0]  interrupt
);

    localparam logic [1:0] ADDR_PEND    = 2'd0;
    localparam logic [1:0] ADDR_CTRL    = 2'd1;
    localparam logic [1:0] ADDR_COUNT   = 2'd2;
    localparam logic [1:0] ADDR_COMPARE = 2'd3;

    logic [SYNC_STAGES-1:0][4:0] sync_q;
    logic [4:0]         irq_s;
    logic [4:0]         irq_h;
    logic [4:0]         irq_rise;
    logic [5:0]         pend;
    logic [5:0]         pend_d;
    logic [5:0]         mask;
    logic [4:0]         edge_mode;
    logic               tmr_en;
    logic [TIMER_W-1:0] count;
    logic [TIMER_W-1:0] compare;
    logic               tmr_match;
    logic               wr_pend;
    logic               wr_ctrl;
    logic               wr_count;
    logic               wr_compare;
    logic [5:0]         w1c;
    logic [31:0]        count_rd;
    logic [31:0]        compare_rd;

    assign wr_pend    = we && (addr == ADDR_PEND);
    assign wr_ctrl    = we && (addr == ADDR_CTRL);
    assign wr_count   = we && (addr == ADDR_COUNT);
    assign wr_compare = we && (addr == ADDR_COMPARE);
    assign w1c        = wr_pend ? wd[5:0] : 6'd0;

    assign irq_s     = sync_q[SYNC_STAGES-1];
    assign irq_rise  = irq_s & ~irq_h;
    // Compare uses the pre-increment / pre-load COUNT value.
    assign tmr_match = tmr_en && (count == compare);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= '0;
            irq_h  <= '0;
        end else begin
            sync_q[0] <= irq_in;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
            irq_h <= irq_s;
        end
    end

    // Set events win over a same-cycle W1C or COMPARE-write clear.
    always_comb begin
        pend_d = pend;
        for (int i = 0; i < 5; i++) begin
            if (edge_mode[i]) begin
                pend_d[i] = irq_rise[i] | (pend[i] & ~w1c[i]);
            end else begin
                pend_d[i] = irq_s[i];
            end
        end
        pend_d[5] = tmr_match | (pend[5] & ~(w1c[5] | wr_compare));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend      <= '0;
            mask      <= '0;
            edge_mode <= '0;
            tmr_en    <= 1'b0;
            count     <= '0;
            compare   <= '1;
        end else begin
            pend <= pend_d;
            if (wr_ctrl) begin
                mask      <= wd[5:0];
                edge_mode <= wd[12:8];
                tmr_en    <= wd[16];
            end
            if (wr_count) begin
                count <= wd[TIMER_W-1:0];
            end else if (tmr_en) begin
                count <= count + TIMER_W'(1);
            end
            if (wr_compare) begin
                compare <= wd[TIMER_W-1:0];
            end
        end
    end

    always_comb begin
        count_rd                  = '0;
        count_rd[TIMER_W-1:0]     = count;
        compare_rd                = '0;
        compare_rd[TIMER_W-1:0]   = compare;
    end

    always_comb begin
        rd = '0;
        case (addr)
            ADDR_PEND:    rd[5:0] = pend;
            ADDR_CTRL:    rd = {15'd0, tmr_en, 3'd0, edge_mode, 2'd0, mask};
            ADDR_COUNT:   rd = count_rd;
            ADDR_COMPARE: rd = compare_rd;
            default:      rd = '0;
        endcase
    end

    assign interrupt = pend & mask;

endmodule
